// File: rtl/spi_peripheral_pkg.sv
// Shared frame geometry, FSM state encoding and address range helper for the SPI register-file target.
package spi_peripheral_pkg;

   localparam int FRAME_BITS = 24;
   localparam int ADDR_WIDTH = 7;
   localparam int DATA_WIDTH = 16;
   localparam int RW_BIT     = 23;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT,
      WAIT_IDLE
   } state_e;

   function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr, input int num_regs);
      return int'(addr) < num_regs;
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes CSB/SCLK/SDI/LE into clk; edge pulses come from the last two chain stages.
// Latency: level after SYNC_STAGES clk, edge pulse acted upon SYNC_STAGES+1 clk after the pin; no backpressure.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic csb_i,
   input  logic sclk_i,
   input  logic sdi_i,
   input  logic le_i,
   output logic csb_o,
   output logic csb_rise_o,
   output logic csb_fall_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic sdi_o,
   output logic le_rise_o
);

   logic [SYNC_STAGES:0]   csb_q;
   logic [SYNC_STAGES:0]   sclk_q;
   logic [SYNC_STAGES:0]   le_q;
   logic [SYNC_STAGES-1:0] sdi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csb_q  <= '1;
         sclk_q <= '0;
         le_q   <= '0;
         sdi_q  <= '0;
      end else begin
         csb_q  <= {csb_q[SYNC_STAGES-1:0], csb_i};
         sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk_i};
         le_q   <= {le_q[SYNC_STAGES-1:0], le_i};
         sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      end
   end

   // Top bit of each chain is the previous value of the synchronized level.
   assign csb_o       = csb_q[SYNC_STAGES-1];
   assign csb_rise_o  =  csb_q[SYNC_STAGES-1] & ~csb_q[SYNC_STAGES];
   assign csb_fall_o  = ~csb_q[SYNC_STAGES-1] &  csb_q[SYNC_STAGES];
   assign sclk_rise_o =  sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
   assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] &  sclk_q[SYNC_STAGES];
   assign le_rise_o   =  le_q[SYNC_STAGES-1] & ~le_q[SYNC_STAGES];
   assign sdi_o       = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral_regfile.sv
// SPI mode-0 target with a 16-bit register bank; SPI_PERIPH_LE_COMMIT_EN defers writes to an SPI_LE rise.
// Latency: pin edge to action SYNC_STAGES+1 clk; no backpressure, master must respect clk >= 8x bit rate.
module spi_peripheral_regfile
   import spi_peripheral_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter logic [15:0] RESET_VALUE = 16'h0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   SPI_CSB,
   input  logic                   SPI_CLK,
   input  logic                   SPI_SDI,
   input  logic                   SPI_LE,
   output logic                   SPI_SDO,
   output logic                   SPI_SDO_OE,
   output logic [NUM_REGS*16-1:0] regs,
   output logic                   wr_strobe,
   output logic [6:0]             wr_addr,
   output logic                   frame_error,
   output logic                   busy
);

   localparam int         IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

   logic csb_s, csb_rise, csb_fall, sclk_rise, sclk_fall, sdi_s, le_rise;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .csb_i      (SPI_CSB),
      .sclk_i     (SPI_CLK),
      .sdi_i      (SPI_SDI),
      .le_i       (SPI_LE),
      .csb_o      (csb_s),
      .csb_rise_o (csb_rise),
      .csb_fall_o (csb_fall),
      .sclk_rise_o(sclk_rise),
      .sclk_fall_o(sclk_fall),
      .sdi_o      (sdi_s),
      .le_rise_o  (le_rise)
   );

   state_e                  state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   rd_q, rd_d;
   logic [2:0]              settle_q, settle_d;
   logic                    sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d;
   logic                    strobe_q, strobe_d, ferr_q, ferr_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

   logic                    commit_ok, len_err, le_err, we;
   logic [ADDR_WIDTH-1:0]   we_addr, rd_addr;
   logic [DATA_WIDTH-1:0]   we_data, rd_lookup;

   assign rd_addr   = {shift_q[ADDR_WIDTH-2:0], sdi_s};
   assign rd_lookup = addr_in_range(rd_addr, NUM_REGS) ? regs_q[rd_addr[IDX_W-1:0]] : '0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      rd_d      = rd_q;
      settle_d  = settle_q;
      sdo_d     = sdo_q;
      oe_d      = oe_q;
      busy_d    = busy_q;
      commit_ok = 1'b0;
      len_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (csb_fall) begin
               cnt_d   = '0;
               shift_d = '0;
               rd_d    = '0;
               sdo_d   = 1'b0;
               oe_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // CSB rise outranks a coincident SCLK edge.
            if (csb_rise) begin
               sdo_d   = 1'b0;
               oe_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = COMMIT;
            end else if (sclk_rise) begin
               shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
               if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7 && shift_q[ADDR_WIDTH-1]) rd_d = rd_lookup;
            end else if (sclk_fall && cnt_q >= 5'd8) begin
               sdo_d = rd_q[DATA_WIDTH-1];
               rd_d  = {rd_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (cnt_q == 5'(FRAME_BITS))
               commit_ok = !shift_q[RW_BIT] &&
                           addr_in_range(shift_q[RW_BIT-1 -: ADDR_WIDTH], NUM_REGS);
            else
               len_err = 1'b1;
         end
         WAIT_IDLE: begin
            // Hold off until the synchronizer chain reflects the pins after reset.
            if (settle_q != SETTLE) settle_d = settle_q + 3'd1;
            else if (csb_s)         state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SPI_PERIPH_LE_COMMIT_EN
   logic                  stg_vld_q, stg_vld_d;
   logic [ADDR_WIDTH-1:0] stg_addr_q, stg_addr_d;
   logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;

   always_comb begin
      stg_vld_d  = stg_vld_q;
      stg_addr_d = stg_addr_q;
      stg_data_d = stg_data_q;
      le_err     = 1'b0;
      if (commit_ok) begin
         stg_vld_d  = 1'b1;
         stg_addr_d = shift_q[RW_BIT-1 -: ADDR_WIDTH];
         stg_data_d = shift_q[DATA_WIDTH-1:0];
      end else if (stg_vld_q && le_rise) begin
         stg_vld_d = 1'b0;
      end else if (stg_vld_q && state_q == IDLE && csb_fall) begin
         stg_vld_d = 1'b0;
         le_err    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld_q  <= 1'b0;
         stg_addr_q <= '0;
         stg_data_q <= '0;
      end else begin
         stg_vld_q  <= stg_vld_d;
         stg_addr_q <= stg_addr_d;
         stg_data_q <= stg_data_d;
      end
   end

   assign we      = stg_vld_q && le_rise;
   assign we_addr = stg_addr_q;
   assign we_data = stg_data_q;
`else
   logic unused_le;
   assign unused_le = le_rise;
   assign le_err    = 1'b0;
   assign we        = commit_ok;
   assign we_addr   = shift_q[RW_BIT-1 -: ADDR_WIDTH];
   assign we_data   = shift_q[DATA_WIDTH-1:0];
`endif

   assign strobe_d = we;
   assign waddr_d  = we ? we_addr : waddr_q;
   assign ferr_d   = len_err | le_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= WAIT_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         rd_q     <= '0;
         settle_q <= '0;
         sdo_q    <= 1'b0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         rd_q     <= rd_d;
         settle_q <= settle_d;
         sdo_q    <= sdo_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
         waddr_q  <= waddr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      end else if (we) begin
         regs_q[we_addr[IDX_W-1:0]] <= we_data;
      end
   end

   assign regs        = regs_q;
   assign SPI_SDO     = sdo_q;
   assign SPI_SDO_OE  = oe_q;
   assign wr_strobe   = strobe_q;
   assign wr_addr     = waddr_q;
   assign frame_error = ferr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_spi_peripheral_regfile.sv
// Directed bench: bit-banged SPI master at clk/10 with hand-computed register, SDO and pulse-count expectations.
module tb_spi_peripheral_regfile;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         csb = 1'b1, sclk = 1'b0, sdi = 1'b0, le = 1'b0;
   logic         sdo, oe, wr_strobe, frame_error, busy;
   logic [127:0] regs;
   logic [6:0]   wr_addr;

   int           ncomp = 0, nfail = 0;
   int           n_strobe = 0, n_err = 0;
   int           s0, e0, bitpos;
   logic [15:0]  cap;
   logic         oe_mid;

   spi_peripheral_regfile #(
      .NUM_REGS   (8),
      .RESET_VALUE(16'hA5C3),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SPI_CSB    (csb),
      .SPI_CLK    (sclk),
      .SPI_SDI    (sdi),
      .SPI_LE     (le),
      .SPI_SDO    (sdo),
      .SPI_SDO_OE (oe),
      .regs       (regs),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .frame_error(frame_error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe === 1'b1)   n_strobe++;
      if (frame_error === 1'b1) n_err++;
   end

   function automatic logic [15:0] reg_at(input int k);
      return regs[16*k +: 16];
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic csb_lo();
      bitpos = 0;
      cap    = '0;
      oe_mid = 1'b0;
      csb    = 1'b0;
      #50;
   endtask

   task automatic csb_hi();
      #50;
      csb = 1'b1;
      #100;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sdi = v[i];
         #50;
         if (bitpos >= 8 && bitpos < 24) cap = {cap[14:0], sdo};
         if (bitpos == 4) oe_mid = oe;
         bitpos++;
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] v, input int n);
      csb_lo();
      send_bits(v, n);
      csb_hi();
   endtask

   task automatic le_pulse();
      le = 1'b1;
      #50;
      le = 1'b0;
      #100;
   endtask

   task automatic wr(input logic [6:0] a, input logic [15:0] d);
      frame({8'h00, 1'b0, a, d}, 24);
`ifdef SPI_PERIPH_LE_COMMIT_EN
      le_pulse();
`endif
   endtask

   task automatic rd(input logic [6:0] a);
      frame({8'h00, 1'b1, a, 16'h0000}, 24);
   endtask

   initial begin
      // Reset state
      #30;
      check("rst_sdo", sdo, 0);
      check("rst_oe", oe, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_ferr", frame_error, 0);
      check("rst_busy", busy, 0);
      check("rst_regs", regs, {8{16'hA5C3}});
      rst_n = 1'b1;
      #100;

      // 1: write 0x03_BEEF
      s0 = n_strobe; e0 = n_err;
      wr(7'h03, 16'hBEEF);
      check("wr3_reg", reg_at(3), 16'hBEEF);
      check("wr3_other", reg_at(2), 16'hA5C3);
      check("wr3_strobes", n_strobe - s0, 1);
      check("wr3_addr", wr_addr, 7'h03);
      check("wr3_noerr", n_err - e0, 0);
      check("wr3_sdo_quiet", cap, 16'h0000);
      check("wr3_oe_mid", oe_mid, 1);
      check("wr3_oe_after", oe, 0);
      check("wr3_busy_after", busy, 0);

      // 2: read back 0x83_0000
      s0 = n_strobe; e0 = n_err;
      rd(7'h03);
      check("rd3_data", cap, 16'hBEEF);
      check("rd3_oe_mid", oe_mid, 1);
      check("rd3_oe_after", oe, 0);
      check("rd3_reg", reg_at(3), 16'hBEEF);
      check("rd3_strobes", n_strobe - s0, 0);
      check("rd3_noerr", n_err - e0, 0);

      // First and last register, MSB/LSB boundary data
      wr(7'h00, 16'h8001);
      rd(7'h00);
      check("rd0_data", cap, 16'h8001);
      wr(7'h07, 16'h5AA5);
      check("wr7_addr", wr_addr, 7'h07);
      rd(7'h07);
      check("rd7_data", cap, 16'h5AA5);

      // 3: short and long frames
      s0 = n_strobe; e0 = n_err;
      frame(32'h0000_0512, 16);
      check("short_err", n_err - e0, 1);
      frame(32'h0004_1234, 25);
      check("long_err", n_err - e0, 2);
      check("len_strobes", n_strobe - s0, 0);
      check("len_reg4", reg_at(4), 16'hA5C3);

      // 4: out-of-range address
      s0 = n_strobe; e0 = n_err;
      wr(7'h7F, 16'h1111);
      check("oor_strobes", n_strobe - s0, 0);
      check("oor_noerr", n_err - e0, 0);
      check("oor_regs", regs, {16'h5AA5, 16'hA5C3, 16'hA5C3, 16'hA5C3,
                               16'hBEEF, 16'hA5C3, 16'hA5C3, 16'h8001});
      rd(7'h7F);
      check("oor_rd_data", cap, 16'h0000);
      check("oor_rd_noerr", n_err - e0, 0);

      // 5: reset after 12 bits of 0x06_CAFE, released with CSB still low
      s0 = n_strobe; e0 = n_err;
      csb_lo();
      send_bits(32'h0000_006C, 12);
      rst_n = 1'b0;
      #30;
      check("midrst_busy", busy, 0);
      check("midrst_oe", oe, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_reg3", reg_at(3), 16'hA5C3);
      rst_n = 1'b1;
      #50;
      send_bits(32'h0000_0AFE, 12);
      check("waitidle_busy", busy, 0);
      check("waitidle_oe", oe, 0);
      csb_hi();
      check("abort_strobes", n_strobe - s0, 0);
      check("abort_noerr", n_err - e0, 0);
      check("abort_reg6", reg_at(6), 16'hA5C3);
      wr(7'h06, 16'hCAFE);
      check("post_rst_reg6", reg_at(6), 16'hCAFE);
      check("post_rst_strobes", n_strobe - s0, 1);
      check("post_rst_addr", wr_addr, 7'h06);

`ifdef SPI_PERIPH_LE_COMMIT_EN
      // 6: latch-enable deferred commit
      s0 = n_strobe; e0 = n_err;
      frame({8'h00, 1'b0, 7'h01, 16'h1234}, 24);
      check("le_hold_reg1", reg_at(1), 16'hA5C3);
      check("le_hold_strobes", n_strobe - s0, 0);
      le_pulse();
      check("le_reg1", reg_at(1), 16'h1234);
      check("le_strobes", n_strobe - s0, 1);
      check("le_addr", wr_addr, 7'h01);
      frame({8'h00, 1'b0, 7'h01, 16'h5678}, 24);
      rd(7'h01);
      check("le_discard_err", n_err - e0, 1);
      check("le_discard_rd", cap, 16'h1234);
      check("le_discard_reg1", reg_at(1), 16'h1234);
      check("le_discard_strobes", n_strobe - s0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule

// File: doc/spi_peripheral_regfile.md
Name: spi_peripheral_regfile

Overview:
- SPI responder (target) for the 24-bit MSB-first frames our SPI masters emit toward AFE-style devices.
- Oversamples SPI_CSB, SPI_CLK and SPI_SDI in the `clk` domain, decodes read/write frames, and maintains a small 16-bit register bank. Read data is returned on SPI_SDO.
- Used as a loopback/emulation target for AFE devices and as a control port for downstream FPGAs.

Parameters:
- NUM_REGS, 8: number of 16-bit registers, 1..128.
- RESET_VALUE, 16'h0000: reset value of every register.
- SYNC_STAGES, 2: synchronizer depth for the SPI inputs, 2..3.

Ports:
- clk  in  1  system clock. Must satisfy clk >= 8 x SPI bit rate.
- rst_n  in  1  asynchronous active-low reset.
- SPI_CSB  in  1  chip select, active low.
- SPI_CLK  in  1  SPI clock, CPOL=0.
- SPI_SDI  in  1  data from master.
- SPI_LE  in  1  latch-enable pulse from master. Used only with the optional feature.
- SPI_SDO  out  1  data to master.
- SPI_SDO_OE  out  1  SDO output enable; 1 only while the synchronized CSB is low.
- regs  out  NUM_REGS*16  flat register bank; reg k occupies bits [16k+:16].
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  7  address of the last write. Valid with wr_strobe.
- frame_error  out  1  one-cycle pulse when a frame is discarded.
- busy  out  1  high while a frame is in progress (synchronized CSB low).

Behaviour:
- Reset values:
  - SPI_SDO=0, SPI_SDO_OE=0, all registers=RESET_VALUE.
  - wr_strobe=0, wr_addr=0, frame_error=0, busy=0.
  - Synchronizers: CSB stages=1, CLK stages=0, SDI stages=0.
- Frame format (MSB first): bit23 R/W (1=read), bits22:16 address, bits15:0 data.
- SPI mode 0:
  - SDI is sampled on the detected rising edge of SPI_CLK.
  - SDO is updated on the detected falling edge.
- Edge detection uses the last two synchronizer outputs; latency from pin edge to action is SYNC_STAGES+1 clk.
- States:
  - IDLE: wait for synchronized CSB 1->0. On that edge: bit counter=0, shift reg cleared, SDO=0, OE=1, busy=1, go to SHIFT.
  - SHIFT:
    - On each rising SCLK: shift SDI in and increment the bit counter. The counter is 5 bits and saturates at 31.
    - After the 8th rising edge, if R/W=1: load read data. Data is regs[addr], or 16'h0000 if addr >= NUM_REGS.
    - On each falling SCLK after bit 8: SDO = next read-data bit, MSB first. For writes SDO stays 0.
    - On synchronized CSB 0->1: go to COMMIT.
  - COMMIT (1 clk), non-LE build:
    - Write frame with exactly 24 bits and addr < NUM_REGS: update the register, pulse wr_strobe, set wr_addr.
    - Read frame with exactly 24 bits: no side effect.
    - Bit count != 24: pulse frame_error, no write.
    - Write to addr >= NUM_REGS: silently ignored, no error.
    - Then OE=0, busy=0, go to IDLE.
  - WAIT_IDLE: entered from reset deassertion if synchronized CSB is low. The partial frame is ignored; return to IDLE only after CSB is seen high.
- SCLK edges while CSB is high are ignored.
- Reset mid-frame: everything returns to reset values immediately. No write and no error pulse for the aborted frame.
- Back-to-back frames:
  - CSB high for >= SYNC_STAGES+2 clk is required between frames.
  - A CSB rise detected in the same clk as an SCLK edge: the CSB rise wins and that SCLK edge is not counted.

Optional Feature:
- Macro: SPI_PERIPH_LE_COMMIT_EN.
- Defined:
  - A valid 24-bit write frame is staged (address and data held) instead of committed at COMMIT.
  - The write is applied, with wr_strobe, on the next synchronized SPI_LE rising edge.
  - A new CSB fall before that LE edge discards the staged write and pulses frame_error.
  - Read frames do not stage anything.
- Undefined: SPI_LE is ignored and writes commit at CSB rise as above.

Decomposition:
- Package spi_peripheral_pkg holds:
  - FRAME_BITS=24, ADDR_WIDTH=7, DATA_WIDTH=16, RW_BIT=23.
  - The state enum (IDLE, SHIFT, COMMIT, WAIT_IDLE).
- Sub-module spi_input_sync: SYNC_STAGES-deep synchronizer for CSB/CLK/SDI. It outputs clean levels plus one-cycle rise/fall pulses for CSB and CLK.

Test Plan:
1. Write frame 0x03_BEEF (R/W=0, addr 3) at clk/10 bit rate -> regs[3]=16'hBEEF; one wr_strobe with wr_addr=3; no frame_error.
2. Then read frame 0x83_0000 -> master captures 16'hBEEF on SDO over bits 8..23; regs unchanged; SDO_OE high only while CSB low.
3. Frame of 16 bits, then a frame of 25 bits -> two frame_error pulses; no register changes.
4. Write to addr 0x7F with NUM_REGS=8 -> no write and no error. Read of addr 0x7F -> SDO returns 0x0000.
5. Assert rst_n=0 after 12 bits of a write; release while CSB is still low -> no write; block stays in WAIT_IDLE until CSB rises; next full frame is accepted.
6. With SPI_PERIPH_LE_COMMIT_EN: write 0x01_1234 -> regs[1] unchanged until an SPI_LE pulse, then 16'h1234 with wr_strobe. A second write followed by a new CSB fall before LE -> frame_error pulse; regs[1] stays 16'h1234.
